// File: rtl/mem_bus_arbiter_if.sv
// Port bundle for mem_bus_arbiter: fetch port, data port, memory bus and stall requests.
// slave is the arbiter's view; master is the CPU/memory side that drives its inputs.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ready_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [3:0]        mem_sel_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_ready_o;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [3:0]        bus_sel_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;

  logic              stallreq_if_o;
  logic              stallreq_mem_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  bus_rdata_i, bus_ack_i,
    output if_data_o, if_ready_o, mem_rdata_o, mem_ready_o,
    output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    output stallreq_if_o, stallreq_mem_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output bus_rdata_i, bus_ack_i,
    input  if_data_o, if_ready_o, mem_rdata_o, mem_ready_o,
    input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    input  stallreq_if_o, stallreq_mem_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one variable-latency memory bus between instruction fetch and the data port.
// Data wins contested arbitrations until STARVE_LIMIT in a row, then fetch gets one turn.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  mem_bus_arbiter_if.slave arb
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic              lat_we, we_nxt;
  logic [3:0]        lat_sel, sel_nxt;
  logic [ADDR_W-1:0] lat_addr, addr_nxt;
  logic [DATA_W-1:0] lat_wdata, wdata_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_we     <= 1'b0;
      lat_sel    <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      lat_we     <= we_nxt;
      lat_sel    <= sel_nxt;
      lat_addr   <= addr_nxt;
      lat_wdata  <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    we_nxt     = lat_we;
    sel_nxt    = lat_sel;
    addr_nxt   = lat_addr;
    wdata_nxt  = lat_wdata;
    case (state)
      IDLE: begin
        // Data wins unless fetch is also waiting and has already lost LIMIT contests in a row
        if (arb.mem_req_i && (!arb.if_req_i || (starve_cnt < LIMIT))) begin
          state_nxt = GRANT_D;
          if (arb.if_req_i) starve_nxt = starve_cnt + 4'd1;
          we_nxt    = arb.mem_we_i;
          sel_nxt   = arb.mem_sel_i;
          addr_nxt  = arb.mem_addr_i;
          wdata_nxt = arb.mem_wdata_i;
        end else if (arb.if_req_i) begin
          state_nxt  = GRANT_I;
          starve_nxt = '0;
          we_nxt     = 1'b0;
          sel_nxt    = 4'b1111;
          addr_nxt   = arb.if_addr_i;
          wdata_nxt  = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (arb.bus_ack_i) begin
          state_nxt = IDLE;
          we_nxt    = 1'b0;
          sel_nxt   = '0;
          addr_nxt  = '0;
          wdata_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign arb.bus_req_o   = (state != IDLE);
  assign arb.bus_we_o    = lat_we;
  assign arb.bus_sel_o   = lat_sel;
  assign arb.bus_addr_o  = lat_addr;
  assign arb.bus_wdata_o = lat_wdata;

  assign arb.if_ready_o  = (state == GRANT_I) && arb.bus_ack_i;
  assign arb.mem_ready_o = (state == GRANT_D) && arb.bus_ack_i;
  assign arb.if_data_o   = arb.if_ready_o  ? arb.bus_rdata_i : '0;
  assign arb.mem_rdata_o = arb.mem_ready_o ? arb.bus_rdata_i : '0;

  assign arb.stallreq_if_o  = arb.if_req_i  && !arb.if_ready_o;
  assign arb.stallreq_mem_o = arb.mem_req_i && !arb.mem_ready_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level ownership model,
// followed by a directed contention run that checks the data/fetch grant pattern.
module tb_mem_bus_arbiter;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bi ();

  mem_bus_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(bi)
  );

  typedef struct {
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  // Model: who owns the bus (0 none, 1 fetch, 2 data), the transaction it is
  // running, and how many contests fetch has lost since it last got the bus.
  int          m_owner;
  int unsigned m_losses;
  txn_t        m_txn;
  bit          m_valid;
  bit          last_if_rdy, last_mem_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic txn_t fetch_txn(input logic [AW-1:0] a);
    txn_t t;
    t.we = 1'b0; t.sel = 4'hF; t.addr = a; t.wdata = '0;
    return t;
  endfunction

  function automatic txn_t data_txn();
    txn_t t;
    t.we = bi.mem_we_i; t.sel = bi.mem_sel_i; t.addr = bi.mem_addr_i; t.wdata = bi.mem_wdata_i;
    return t;
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    if (!rst) begin
      m_owner  = 0;
      m_losses = 0;
      m_txn    = '{default: '0};
      m_valid  = 1'b1;
    end else if (m_owner == 0) begin
      if (bi.if_req_i && bi.mem_req_i && m_losses >= LIMIT) begin
        m_owner = 1; m_losses = 0; m_txn = fetch_txn(bi.if_addr_i);
      end else if (bi.mem_req_i) begin
        m_owner = 2; m_txn = data_txn();
        if (bi.if_req_i) m_losses++;
      end else if (bi.if_req_i) begin
        m_owner = 1; m_losses = 0; m_txn = fetch_txn(bi.if_addr_i);
      end
    end else if (bi.bus_ack_i) begin
      m_owner = 0;
      m_txn   = '{default: '0};
    end
  endtask

  task automatic check_outputs();
    logic          e_req, e_ifr, e_memr;
    logic [DW-1:0] e_ifd, e_memd;
    if (!m_valid) return;
    e_req  = (m_owner != 0);
    e_ifr  = (m_owner == 1) && bi.bus_ack_i;
    e_memr = (m_owner == 2) && bi.bus_ack_i;
    e_ifd  = e_ifr  ? bi.bus_rdata_i : '0;
    e_memd = e_memr ? bi.bus_rdata_i : '0;
    check_val("bus_req",   64'(bi.bus_req_o),   64'(e_req));
    check_val("bus_we",    64'(bi.bus_we_o),    64'(m_txn.we));
    check_val("bus_sel",   64'(bi.bus_sel_o),   64'(m_txn.sel));
    check_val("bus_addr",  64'(bi.bus_addr_o),  64'(m_txn.addr));
    check_val("bus_wdata", 64'(bi.bus_wdata_o), 64'(m_txn.wdata));
    check_val("if_ready",  64'(bi.if_ready_o),  64'(e_ifr));
    check_val("if_data",   64'(bi.if_data_o),   64'(e_ifd));
    check_val("mem_ready", 64'(bi.mem_ready_o), 64'(e_memr));
    check_val("mem_rdata", 64'(bi.mem_rdata_o), 64'(e_memd));
    check_val("stall_if",  64'(bi.stallreq_if_o),  64'(bi.if_req_i && !e_ifr));
    check_val("stall_mem", 64'(bi.stallreq_mem_o), 64'(bi.mem_req_i && !e_memr));
    last_if_rdy  = e_ifr;
    last_mem_rdy = e_memr;
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_random(input bit force_reset);
    rst = force_reset ? 1'b0 : ($urandom_range(0, 79) != 0);
    if (!bi.if_req_i || last_if_rdy) bi.if_req_i = ($urandom_range(0, 1) == 0);
    else if ($urandom_range(0, 29) == 0) bi.if_req_i = 1'b0;
    if (!bi.mem_req_i || last_mem_rdy) bi.mem_req_i = ($urandom_range(0, 1) == 0);
    else if ($urandom_range(0, 29) == 0) bi.mem_req_i = 1'b0;
    bi.if_addr_i   = $urandom;
    bi.mem_we_i    = 1'($urandom_range(0, 1));
    bi.mem_sel_i   = 4'($urandom_range(0, 15));
    bi.mem_addr_i  = $urandom;
    bi.mem_wdata_i = $urandom;
    bi.bus_ack_i   = ($urandom_range(0, 2) == 0);
    bi.bus_rdata_i = $urandom;
  endtask

  logic q_we[$];
  logic exp_seq[6];

  initial begin
    rst = 1'b0;
    bi.if_req_i = 1'b0; bi.if_addr_i = '0;
    bi.mem_req_i = 1'b0; bi.mem_we_i = 1'b0; bi.mem_sel_i = '0;
    bi.mem_addr_i = '0; bi.mem_wdata_i = '0;
    bi.bus_ack_i = 1'b0; bi.bus_rdata_i = '0;
    m_valid = 1'b0; m_owner = 0; m_losses = 0; m_txn = '{default: '0};
    last_if_rdy = 1'b0; last_mem_rdy = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++) begin
      drive_random(i < 2);
      step();
    end

    // Both ports requesting forever, memory acking every cycle: LIMIT data
    // grants, one fetch grant, then data again.
    rst = 1'b0;
    bi.bus_ack_i = 1'b0;
    step();
    rst = 1'b1;
    bi.if_req_i = 1'b1; bi.if_addr_i = 32'h0000_0010;
    bi.mem_req_i = 1'b1; bi.mem_we_i = 1'b1; bi.mem_sel_i = 4'b0011;
    bi.mem_addr_i = 32'h0000_0100; bi.mem_wdata_i = 32'hDEAD_BEEF;
    bi.bus_ack_i = 1'b1; bi.bus_rdata_i = 32'h3401_0020;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bi.bus_req_o === 1'b1) q_we.push_back(bi.bus_we_o);
      step();
    end
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    check_val("starve_grant_count_ge6", 64'(q_we.size() >= 6), 64'd1);
    for (int k = 0; k < 6; k++) begin
      if (k < q_we.size()) check_val($sformatf("starve_grant_%0d", k), 64'(q_we[k]), 64'(exp_seq[k]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port, variable-latency memory bus between the instruction-fetch port (driven by pc_reg) and the data port (driven by the MEM stage).
- Sits between the CPU top and the external unified memory.
- Raises per-port stall requests to ctrl until each access completes.
- Data side has priority; a starvation counter bounds how long instruction fetch can be locked out.

Parameters:
- ADDR_W, 32, address width of both ports and the bus
- DATA_W, 32, data width of both ports and the bus
- STARVE_LIMIT, 4, consecutive contested data grants after which instruction fetch wins the next contested arbitration (legal range 1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- if_req_i  in  1  fetch request; held until if_ready_o
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  DATA_W  fetch data; valid only while if_ready_o=1
- if_ready_o  out  1  fetch done, one-cycle pulse
- mem_req_i  in  1  data request; held until mem_ready_o
- mem_we_i  in  1  1=write, 0=read
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  DATA_W  write data
- mem_rdata_o  out  DATA_W  read data; valid only while mem_ready_o=1
- mem_ready_o  out  1  data access done, one-cycle pulse
- bus_req_o  out  1  bus transaction active
- bus_we_o  out  1  bus write enable
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_rdata_i  in  DATA_W  bus read data; valid with bus_ack_i
- bus_ack_i  in  1  transaction complete, one-cycle pulse from memory
- stallreq_if_o  out  1  fetch stall request to ctrl
- stallreq_mem_o  out  1  data stall request to ctrl

Behaviour:
- State machine: IDLE, GRANT_I, GRANT_D. State register, latched bus fields and starve_cnt (4 bits) are registered.
- Reset (rst=0 at a rising edge):
  - state=IDLE, starve_cnt=0.
  - bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o all 0.
  - if_ready_o=mem_ready_o=0; if_data_o=mem_rdata_o=0.
  - Applies mid-transaction; a bus_ack_i arriving after reset is ignored.
- IDLE, arbitration:
  - Only mem_req_i=1: go to GRANT_D.
  - Only if_req_i=1: go to GRANT_I.
  - Both requesting, starve_cnt<STARVE_LIMIT: GRANT_D, starve_cnt+=1.
  - Both requesting, starve_cnt==STARVE_LIMIT: GRANT_I.
  - Any entry to GRANT_I clears starve_cnt. Uncontested GRANT_D leaves starve_cnt unchanged.
  - On the transition edge, latch the winner's addr, we, sel and wdata. Fetch grants use we=0, sel=4'b1111, wdata=0.
- GRANT_x:
  - bus_req_o=1 and the latched fields are driven stable every cycle.
  - Port inputs are ignored after latching.
  - Hold the state until bus_ack_i=1.
- Completion:
  - In the cycle bus_ack_i=1 in GRANT_x, x_ready_o=1 combinationally.
  - The matching data output equals bus_rdata_i that cycle, for writes too; the requester ignores it.
  - Next edge: state=IDLE, bus_req_o=0, bus fields cleared to 0.
- bus_ack_i while in IDLE: ignored; no ready pulse.
- Latency and throughput:
  - Request first seen in IDLE at cycle N; bus_req_o=1 from N+1; earliest ready at N+1.
  - A mandatory IDLE cycle follows each completion, so peak rate is one access per 2 cycles.
- Stall requests:
  - stallreq_if_o = if_req_i & ~if_ready_o.
  - stallreq_mem_o = mem_req_i & ~mem_ready_o.
  - Both are combinational, so ctrl freezes the pipeline in the same cycle.
- Request withdrawn mid-transaction (e.g. pipeline flush): the bus transaction runs to ack and ready still pulses. The requester discards the result; no abort exists.
- The ready outputs and their data outputs are 0 whenever the corresponding ready is not asserted.

Test Plan:
- Reset, then fetch only: if_req_i=1, if_addr_i=0x0000_0010, ack 3 cycles after bus_req_o rises with rdata=0x3401_0020 -> bus_addr_o=0x10, bus_we_o=0, bus_sel_o=4'hF; if_ready_o=1 and if_data_o=0x3401_0020 in the ack cycle only; stallreq_if_o=1 until then.
- Contention: both ports request, data is a write to 0x100 with sel=4'b0011 and wdata=0xDEAD_BEEF, ack after 1 cycle -> data granted first with bus_we_o=1, bus_sel_o=3, wdata driven; fetch granted after one IDLE cycle; stallreq_if_o stays 1 throughout.
- Starvation with STARVE_LIMIT=4: if_req_i held high, mem_req_i re-asserted every IDLE cycle -> exactly 4 data grants, then a fetch grant, then starve_cnt=0 and data wins again.
- Reset mid-transaction: rst=0 for one edge while in GRANT_D with ack pending, then ack arrives -> bus_req_o=0 after the reset edge; ack ignored; mem_ready_o stays 0.
- Stray ack: bus_ack_i=1 in IDLE with no request -> no ready pulse; state remains IDLE.
- Withdrawal: mem_req_i drops after grant; ack with rdata=0x1234_5678 -> mem_ready_o pulses with 0x1234_5678; state returns to IDLE; stallreq_mem_o=0.
